// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin grant arbiter.
//   state_t   : arbiter FSM states (GAP is used only when GRANT_GAP_EN is defined)
//   rr_pick_t : winner index plus found flag
//   rr_pick() : round-robin search over NUM_REQ requests from a start index
package arb_pkg;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned IDX_W   = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } rr_pick_t;

    // The first set bit at or after start wins, wrapping around.
    // The loop runs from the farthest candidate down to the nearest one,
    // so the nearest set bit is written last and wins.
    function automatic rr_pick_t rr_pick(input logic [NUM_REQ-1:0] req,
                                         input logic [IDX_W-1:0]   start);
        rr_pick_t         res;
        logic [IDX_W-1:0] cand;
        res.found = 1'b0;
        res.idx   = start;
        for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
            cand = start + IDX_W'(k);
            if (req[cand]) begin
                res.found = 1'b1;
                res.idx   = cand;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/decoder_2_to_4_df.sv
// Existing dataflow 2-to-4 decoder with an active-low enable.
//   A1, A0 : select inputs
//   E      : enable, active-low (1 forces all outputs low)
//   Y3..Y0 : active-high one-hot outputs
module decoder_2_to_4_df (
    input  logic A1,
    input  logic A0,
    input  logic E,
    output logic Y3,
    output logic Y2,
    output logic Y1,
    output logic Y0
);

    assign Y0 = ~E & ~A1 & ~A0;
    assign Y1 = ~E & ~A1 &  A0;
    assign Y2 = ~E &  A1 & ~A0;
    assign Y3 = ~E &  A1 &  A0;

endmodule

// File: rtl/decoder_grant_arbiter.sv
// Round-robin arbiter granting one of four requesters a shared resource.
// The owner index and the active-low enable are registered and then decoded
// by decoder_2_to_4_df into the one-hot grant vector.
//   clk      : clock
//   rst      : synchronous active-high reset
//   req      : level-sensitive request vector
//   gnt      : one-hot grant {Y3..Y0}, zero while disabled
//   gnt_idx  : registered current/last owner index
//   dec_en_n : registered decoder enable, active-low
//   busy     : high while in GRANT
// Parameter MAX_HOLD bounds consecutive grant cycles while others wait (0 = unlimited).
// Optional macro GRANT_GAP_EN inserts a one-cycle GAP on every ownership change.
module decoder_grant_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               dec_en_n,
    output logic               busy
);

    localparam int unsigned HOLD_W = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);

    state_t             state_q,    state_d;
    logic [IDX_W-1:0]   gnt_idx_q,  gnt_idx_d;
    logic [IDX_W-1:0]   last_q,     last_d;
    logic               dec_en_n_q, dec_en_n_d;
    logic               busy_q,     busy_d;
    logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;

    logic [NUM_REQ-1:0] others;
    rr_pick_t           pick_all;
    rr_pick_t           pick_oth;
    logic               preempt;

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_idx_q  <= '0;
            last_q     <= IDX_W'(NUM_REQ - 1);
            dec_en_n_q <= 1'b1;
            busy_q     <= 1'b0;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_idx_q  <= gnt_idx_d;
            last_q     <= last_d;
            dec_en_n_q <= dec_en_n_d;
            busy_q     <= busy_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        gnt_idx_d  = gnt_idx_q;
        last_d     = last_q;
        dec_en_n_d = dec_en_n_q;
        busy_d     = busy_q;
        hold_cnt_d = hold_cnt_q;

        // Masking the owner only matters for preemption; on release req[o] is already 0.
        others   = req & ~(NUM_REQ'(1) << gnt_idx_q);
        pick_all = rr_pick(req,    last_q + IDX_W'(1));
        pick_oth = rr_pick(others, last_q + IDX_W'(1));
        preempt  = (MAX_HOLD != 0) && req[gnt_idx_q] && pick_oth.found &&
                   ((32'(hold_cnt_q) + 32'd1) >= MAX_HOLD);

        case (state_q)
            IDLE, GAP: begin
                hold_cnt_d = '0;
                if (pick_all.found) begin
                    state_d    = GRANT;
                    gnt_idx_d  = pick_all.idx;
                    last_d     = pick_all.idx;
                    dec_en_n_d = 1'b0;
                    busy_d     = 1'b1;
                end else begin
                    state_d    = IDLE;
                    dec_en_n_d = 1'b1;
                    busy_d     = 1'b0;
                end
            end

            GRANT: begin
                if (req[gnt_idx_q] && !preempt) begin
                    if (32'(hold_cnt_q) < MAX_HOLD) begin
                        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                    end
                end else if (pick_oth.found) begin
                    hold_cnt_d = '0;
`ifdef GRANT_GAP_EN
                    // Winner is re-evaluated on GAP exit with the req seen then.
                    state_d    = GAP;
                    dec_en_n_d = 1'b1;
                    busy_d     = 1'b0;
`else
                    gnt_idx_d  = pick_oth.idx;
                    last_d     = pick_oth.idx;
`endif
                end else begin
                    state_d    = IDLE;
                    hold_cnt_d = '0;
                    dec_en_n_d = 1'b1;
                    busy_d     = 1'b0;
                end
            end

            default: begin
                state_d    = IDLE;
                hold_cnt_d = '0;
                dec_en_n_d = 1'b1;
                busy_d     = 1'b0;
            end
        endcase
    end

    // Grant decode straight from registers, so at most one bit is ever high.
    decoder_2_to_4_df u_dec (
        .A1 (gnt_idx_q[1]),
        .A0 (gnt_idx_q[0]),
        .E  (dec_en_n_q),
        .Y3 (gnt[3]),
        .Y2 (gnt[2]),
        .Y1 (gnt[1]),
        .Y0 (gnt[0])
    );

    assign gnt_idx  = gnt_idx_q;
    assign dec_en_n = dec_en_n_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_decoder_grant_arbiter.sv
// Self-checking bench for decoder_grant_arbiter: directed scenarios followed by
// random traffic, all checked against a behavioural owner/pointer model.
module tb_decoder_grant_arbiter;

    localparam int MH = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0000;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       dec_en_n;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;

    // Model: owner is -1 when nobody holds the resource.
    int m_owner = -1;
    int m_idx   = 0;
    int m_last  = 3;
    int m_hold  = 0;
    bit m_gap   = 1'b0;

    decoder_grant_arbiter #(.MAX_HOLD(MH)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .gnt      (gnt),
        .gnt_idx  (gnt_idx),
        .dec_en_n (dec_en_n),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    function automatic int rr(input logic [3:0] r, input int last);
        for (int d = 1; d <= 4; d++) begin
            if (r[(last + d) % 4]) return (last + d) % 4;
        end
        return -1;
    endfunction

    task automatic model_step(input logic [3:0] r, input logic rs);
        int w;
        logic [3:0] oth;
        if (rs) begin
            m_owner = -1; m_idx = 0; m_last = 3; m_hold = 0; m_gap = 1'b0;
        end else if (m_gap || m_owner < 0) begin
            m_gap = 1'b0;
            w = rr(r, m_last);
            if (w >= 0) begin
                m_owner = w; m_idx = w; m_last = w; m_hold = 0;
            end
        end else begin
            oth = r;
            oth[m_owner] = 1'b0;
            w = rr(oth, m_last);
            if (r[m_owner] && !(MH != 0 && m_hold >= MH - 1 && oth != 4'b0000)) begin
                if (m_hold < MH) m_hold++;
            end else if (w >= 0) begin
                m_hold = 0;
`ifdef GRANT_GAP_EN
                m_owner = -1;
                m_gap   = 1'b1;
`else
                m_owner = w; m_idx = w; m_last = w;
`endif
            end else begin
                m_owner = -1; m_hold = 0;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Apply inputs, clock once, advance the model, compare every output.
    task automatic cycle(input logic [3:0] r, input logic rs, input string tag);
        logic [3:0] eg;
        req = r;
        rst = rs;
        @(posedge clk);
        model_step(r, rs);
        #1;
        eg = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
        chk({tag, ".gnt"},      32'(gnt),      32'(eg));
        chk({tag, ".gnt_idx"},  32'(gnt_idx),  32'(m_idx));
        chk({tag, ".dec_en_n"}, 32'(dec_en_n), 32'(m_owner < 0));
        chk({tag, ".busy"},     32'(busy),     32'(m_owner >= 0));
        chk({tag, ".onehot"},   32'($countones(gnt) <= 1), 32'd1);
    endtask

    initial begin
        logic [3:0] r;

        // Reset with everyone requesting
        cycle(4'b1111, 1'b1, "rst0");
        cycle(4'b1111, 1'b1, "rst1");
        chk("rst_gnt_const", 32'(gnt), 32'd0);
        chk("rst_en_const",  32'(dec_en_n), 32'd1);

        // Rotation, 8 cycles per owner
        for (int c = 0; c < 40; c++) begin
            cycle(4'b1111, 1'b0, "rot");
`ifndef GRANT_GAP_EN
            chk("rot_const", 32'(gnt), 32'(4'b0001 << ((c / 8) % 4)));
`endif
        end

        // Release switch: owner 1, then req=1001
        cycle(4'b0000, 1'b1, "rs_rst");
        cycle(4'b0010, 1'b0, "rs_own1");
        chk("rs_own1_const", 32'(gnt), 32'b0010);
        cycle(4'b1001, 1'b0, "rs_sw");
`ifndef GRANT_GAP_EN
        chk("rs_sw_const", 32'(gnt), 32'b1000);
`endif
        cycle(4'b1001, 1'b0, "rs_hold");
        cycle(4'b0001, 1'b0, "rs_rel");
        cycle(4'b0001, 1'b0, "rs_rel2");
        chk("rs_rel_const", 32'(gnt), 32'b0001);

        // Idle return
        cycle(4'b0000, 1'b1, "ir_rst");
        for (int c = 0; c < 3; c++) cycle(4'b0100, 1'b0, "ir_on");
        chk("ir_on_const", 32'(gnt), 32'b0100);
        cycle(4'b0000, 1'b0, "ir_off");
        cycle(4'b0000, 1'b0, "ir_off2");
        chk("ir_idx_const", 32'(gnt_idx), 32'd2);
        chk("ir_gnt_const", 32'(gnt), 32'd0);

        // Lone requester past the hold limit, then late competitor
        cycle(4'b0000, 1'b1, "lr_rst");
        for (int c = 0; c < 20; c++) cycle(4'b0001, 1'b0, "lr_lone");
        chk("lr_lone_const", 32'(gnt), 32'b0001);
        cycle(4'b0101, 1'b0, "lr_comp");
`ifndef GRANT_GAP_EN
        chk("lr_comp_const", 32'(gnt), 32'b0100);
`endif
        cycle(4'b0101, 1'b0, "lr_comp2");

        // Mid-grant reset
        cycle(4'b0100, 1'b0, "mr_pre");
        cycle(4'b0100, 1'b1, "mr_rst");
        chk("mr_rst_const", 32'(gnt), 32'd0);
        cycle(4'b1111, 1'b0, "mr_restart");
        chk("mr_restart_const", 32'(gnt), 32'b0001);

        // Random traffic with sticky requests and rare resets
        r = 4'b0000;
        for (int c = 0; c < 600; c++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
            end
            cycle(r, ($urandom_range(0, 79) == 0), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/decoder_grant_arbiter.md
Name: decoder_grant_arbiter

Overview:
- Round-robin arbiter sharing one resource among 4 requesters.
- Registers a 2-bit winner index and an active-low enable, then drives them into an instance of the team's existing decoder_2_to_4_df. The decoder's Y3..Y0 outputs form the one-hot grant vector.
- Grants are held while the owner keeps requesting, with an optional hold limit for fairness.
- Sits between requesting blocks and the shared datapath select/enable lines.

Parameters:
- MAX_HOLD, 8: maximum consecutive grant cycles before preemption when another requester waits. 0 means unlimited.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  4  request vector; bit i is requester i; level-sensitive.
- gnt  output  4  one-hot grant, {Y3,Y2,Y1,Y0} from the decoder; all zero when disabled.
- gnt_idx  output  2  registered index of the current or last owner (decoder A1,A0).
- dec_en_n  output  1  registered decoder enable, active-low (1 = disabled, gnt = 0000).
- busy  output  1  1 while in GRANT state.

Behaviour:
- Clock/reset (already decided): one clock, clk; reset, rst, is synchronous and active-high.
- Reset values: state=IDLE, dec_en_n=1, gnt=0000, gnt_idx=00, busy=0, hold_cnt=0, last=3. Last=3 means requester 0 has first priority.
- Winner search: round-robin starting at (last+1) mod 4 and wrapping. Lowest distance from the start wins.
- IDLE:
  - req==0000 → stay in IDLE, dec_en_n=1.
  - Any req set → go to GRANT next edge. gnt_idx=winner, last=winner, dec_en_n=0, hold_cnt=0.
  - Latency: req sampled at edge n, gnt visible after edge n+1 (one cycle).
- GRANT, owner o=gnt_idx:
  - req[o]=1 and no preemption → stay; hold_cnt increments, saturating at MAX_HOLD.
  - Preemption occurs when MAX_HOLD≠0, hold_cnt ≥ MAX_HOLD-1, and any other req bit is set. On the next edge the grant moves to the round-robin winner excluding o: last=new, hold_cnt=0.
  - req[o]=0 with other requests pending → switch directly to the next winner at the next edge (no idle cycle, unless GRANT_GAP_EN).
  - req[o]=0 with nothing pending → IDLE next edge, dec_en_n=1. gnt_idx keeps its last value.
- Hold limit with a lone requester: if the owner alone requests past MAX_HOLD, the grant continues and hold_cnt stays saturated. A late competitor preempts at the next edge.
- Simultaneous release and new request by the same owner in the same cycle: treated as release. That requester re-competes from the rotated pointer.
- rst asserted mid-grant → all registers return to reset values at that edge; gnt=0000 the following cycle.
- gnt is combinational only from registers through the decoder, so it is glitch-free per cycle and at most one bit is ever high.
- hold_cnt width: $clog2(MAX_HOLD+1), minimum 1.

Optional Feature:
- Macro: GRANT_GAP_EN.
- Defined: every ownership change (release-with-pending or preemption) passes through a GAP state for exactly one cycle. In GAP, dec_en_n=1, gnt=0000, busy=0. The winner is computed on exit from GAP using req at that time. Switch latency is 2 edges.
- Undefined: the GAP state is not present; switches take one edge as described above.

Decomposition:
- Package arb_pkg:
  - state enum {IDLE, GRANT, GAP}
  - localparam NUM_REQ=4
  - function rr_pick(req, start) returning the 2-bit winner and a found flag.
- Sub-module: instantiate the existing decoder_2_to_4_df (ports A1,A0,E,Y3..Y0) for the grant decode. Connect E=dec_en_n. No new decoder module is written.

Test Plan:
- Reset: hold rst=1 for 2 cycles with req=1111 → gnt=0000, dec_en_n=1, gnt_idx=00, busy=0. Release rst → gnt=0001 one cycle later.
- Rotation: req=1111 held, MAX_HOLD=8 → gnt sequence 0001 (8 cycles), 0010 (8), 0100 (8), 1000 (8), then back to 0001.
- Release switch: owner 1 granted (gnt=0010), req changes to 1001 → next edge gnt=1000 (start search at 2, wins 3). After 3 releases → gnt=0001.
- Idle return: single req=0100 for 3 cycles then 0000 → gnt=0100 for 3 cycles, then gnt=0000 and dec_en_n=1 one edge after release; gnt_idx stays 10.
- Lone requester: req=0001 for 20 cycles → gnt=0001 throughout. Assert req[2] at cycle 20 → gnt=0100 at the next edge.
- Mid-grant reset: during gnt=0100, pulse rst for 1 cycle with req=0100 → gnt=0000 for one cycle, then gnt=0001 priority restart. With GRANT_GAP_EN: check one 0000 cycle on every ownership change in the rotation test.
